// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the EX stage.
// Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Each operation
// performs one radix-2 step per cycle (XLEN steps in total). Divide-by-zero
// and signed overflow finish in a single cycle.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - operation request; sampled only while idle
//   funct3 - RV32M operation select
//   op1    - rs1 operand, captured on an accepted start
//   op2    - rs2 operand, captured on an accepted start
//   flush  - abort any in-flight operation; wins over start
//   busy   - high while iterating; used as the pipeline stall request
//   done   - one-cycle pulse; result is valid in that cycle
//   result - final result; held until the next done
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        fn_r;
  logic              negHi_r;   // product or quotient must be negated
  logic              negRem_r;  // remainder must be negated
  logic [XLEN-1:0]   opB_r;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_r;     // {high, low}: product or {remainder, quotient}
  logic              busy_r;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  logic              sgn1_s;
  logic              sgn2_s;
  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              special_s;
  logic [XLEN-1:0]   specialRes_s;
  logic [XLEN:0]     mulSum_s;
  logic [XLEN:0]     remShift_s;
  logic [XLEN:0]     diff_s;
  logic [2*XLEN-1:0] nextAcc_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   finalRes_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  // Operand signedness per operation and magnitudes for the unsigned core
  always_comb begin
    sgn1_s = 1'b0;
    sgn2_s = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn1_s = op1[XLEN-1];
        sgn2_s = op2[XLEN-1];
      end
      3'b010: begin
        sgn1_s = op1[XLEN-1];
        sgn2_s = 1'b0;
      end
      default: begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
      end
    endcase
    mag1_s = sgn1_s ? -op1 : op1;
    mag2_s = sgn2_s ? -op2 : op2;
  end

  // Single-cycle divide cases: divide by zero and signed overflow
  always_comb begin
    special_s    = 1'b0;
    specialRes_s = ZERO_X;
    if (funct3[2] && (op2 == ZERO_X)) begin
      special_s    = 1'b1;
      specialRes_s = funct3[1] ? op1 : ONES_X;
    end else if (funct3[2] && !funct3[0] && (op1 == MIN_X) && (op2 == ONES_X)) begin
      special_s    = 1'b1;
      specialRes_s = funct3[1] ? ZERO_X : op1;
    end else begin
      special_s    = 1'b0;
      specialRes_s = ZERO_X;
    end
  end

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    mulSum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opB_r} : {(XLEN+1){1'b0}});
    remShift_s = acc_r[2*XLEN-1:XLEN-1];
    // A set top bit means the trial subtraction borrowed and must be undone
    diff_s     = remShift_s - {1'b0, opB_r};
    if (fn_r[2]) begin
      if (!diff_s[XLEN]) begin
        nextAcc_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        nextAcc_s = {remShift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      nextAcc_s = {mulSum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction and result selection after the last step
  always_comb begin
    prod_s = negHi_r ? -nextAcc_s : nextAcc_s;
    case (fn_r)
      3'b000:                 finalRes_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalRes_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalRes_s = negHi_r ? -nextAcc_s[XLEN-1:0] : nextAcc_s[XLEN-1:0];
      3'b110, 3'b111:         finalRes_s = negRem_r ? -nextAcc_s[2*XLEN-1:XLEN] : nextAcc_s[2*XLEN-1:XLEN];
      default:                finalRes_s = ZERO_X;
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      fn_r     <= 3'b000;
      negHi_r  <= 1'b0;
      negRem_r <= 1'b0;
      opB_r    <= ZERO_X;
      acc_r    <= {(2*XLEN){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_X;
    end else if (flush) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            fn_r     <= funct3;
            negHi_r  <= sgn1_s ^ sgn2_s;
            negRem_r <= sgn1_s;
            // Multiply: multiplier in the low half. Divide: dividend in the low half.
            acc_r    <= {ZERO_X, (funct3[2] ? mag1_s : mag2_s)};
            opB_r    <= funct3[2] ? mag2_s : mag1_s;
            if (special_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= specialRes_s;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              cnt_r   <= CNT_W'(XLEN);
            end
          end
        end
        RUN: begin
          acc_r <= nextAcc_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= finalRes_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
